// File: rtl/traffic_sensor.sv
// Two-direction traffic loop sensor: synchronize and debounce each detector,
// queue arrivals, and retire one car per SERVICE cycles of own-direction green.
module traffic_sensor #(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned SERVICE  = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ew_det,
   input  logic       ns_det,
   input  logic       EWLite,
   input  logic       NSLite,
   output logic       EWCar,
   output logic       NSCar,
   output logic [3:0] ew_queue,
   output logic [3:0] ns_queue,
   output logic       ew_ovf,
   output logic       ns_ovf
);
   localparam int unsigned DW  = 4;
   localparam int unsigned DWP = DW + 1;
   localparam int unsigned SW  = 8;
   localparam int unsigned SWP = SW + 1;
   localparam int unsigned QW  = 4;
   localparam int unsigned NL  = 2;

   // Lane 0 is EW, lane 1 is NS.
   logic [NL-1:0] det_raw;
   logic [NL-1:0] lite;
   logic [NL-1:0] sync1_q, sync2_q;
   logic [NL-1:0] lvl_q, lvl_d;
   logic [NL-1:0] ovf_q, ovf_d;
   logic [NL-1:0] arrive, depart;
   logic [DW-1:0] mis_q   [NL];
   logic [DW-1:0] mis_d   [NL];
   logic [SW-1:0] svc_q   [NL];
   logic [SW-1:0] svc_d   [NL];
   logic [QW-1:0] queue_q [NL];
   logic [QW-1:0] queue_d [NL];

   assign det_raw = {ns_det, ew_det};
   assign lite    = {NSLite, EWLite};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         ovf_q   <= '0;
         for (int i = 0; i < int'(NL); i++) begin
            mis_q[i]   <= '0;
            svc_q[i]   <= '0;
            queue_q[i] <= '0;
         end
      end else begin
         sync1_q <= det_raw;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < int'(NL); i++) begin
            mis_q[i]   <= mis_d[i];
            svc_q[i]   <= svc_d[i];
            queue_q[i] <= queue_d[i];
         end
      end
   end

   always_comb begin
      lvl_d  = lvl_q;
      ovf_d  = ovf_q;
      arrive = '0;
      depart = '0;
      for (int i = 0; i < int'(NL); i++) begin
         mis_d[i]   = '0;
         svc_d[i]   = '0;
         queue_d[i] = queue_q[i];

         // Debounce: accept the synchronized level after DEBOUNCE straight mismatches.
         if (sync2_q[i] != lvl_q[i]) begin
            if (DWP'(mis_q[i]) + DWP'(1) == DWP'(DEBOUNCE)) begin
               lvl_d[i]  = sync2_q[i];
               arrive[i] = sync2_q[i];
            end else begin
               mis_d[i] = mis_q[i] + DW'(1);
            end
         end

         // Partial service intervals are dropped when green or the queue goes away.
         if (lite[i] && (queue_q[i] != '0)) begin
            if (SWP'(svc_q[i]) + SWP'(1) == SWP'(SERVICE)) begin
               depart[i] = 1'b1;
            end else begin
               svc_d[i] = svc_q[i] + SW'(1);
            end
         end

         if (arrive[i] && !depart[i]) begin
            if (queue_q[i] == '1) begin
               ovf_d[i] = 1'b1;
            end else begin
               queue_d[i] = queue_q[i] + QW'(1);
            end
         end else if (depart[i] && !arrive[i]) begin
            queue_d[i] = queue_q[i] - QW'(1);
         end
      end
   end

   assign ew_queue = queue_q[0];
   assign ns_queue = queue_q[1];
   assign ew_ovf   = ovf_q[0];
   assign ns_ovf   = ovf_q[1];
   assign EWCar    = (queue_q[0] != '0);
   assign NSCar    = (queue_q[1] != '0);

endmodule

// File: tb/tb_traffic_sensor.sv
// Self-checking bench for traffic_sensor: directed tables and sequences plus
// random stimulus compared every edge against a behavioural reference model.
module tb_traffic_sensor;
   localparam int unsigned DB = 4;
   localparam int unsigned SV = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ew_det = 1'b0, ns_det = 1'b0;
   logic       EWLite = 1'b0, NSLite = 1'b0;
   logic       EWCar, NSCar, ew_ovf, ns_ovf;
   logic [3:0] ew_queue, ns_queue;

   int vectors = 0;
   int miscompares = 0;

   traffic_sensor #(.DEBOUNCE(DB), .SERVICE(SV)) dut (
      .clock(clock), .reset(reset),
      .ew_det(ew_det), .ns_det(ns_det),
      .EWLite(EWLite), .NSLite(NSLite),
      .EWCar(EWCar), .NSCar(NSCar),
      .ew_queue(ew_queue), .ns_queue(ns_queue),
      .ew_ovf(ew_ovf), .ns_ovf(ns_ovf)
   );

   always #5 clock = ~clock;

   // Reference model: run lengths of disagreement and of serviced green, integer queues.
   int m_s1[2], m_s2[2], m_lvl[2], m_mis[2], m_run[2], m_q[2], m_ovf[2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_s1[d] = 0; m_s2[d] = 0; m_lvl[d] = 0; m_mis[d] = 0;
         m_run[d] = 0; m_q[d] = 0; m_ovf[d] = 0;
      end
   endtask

   task automatic model_edge();
      int det[2];
      int lt[2];
      int arr, dep;
      det[0] = int'(ew_det); det[1] = int'(ns_det);
      lt[0]  = int'(EWLite); lt[1]  = int'(NSLite);
      for (int d = 0; d < 2; d++) begin
         arr = 0;
         dep = 0;
         if (m_s2[d] != m_lvl[d]) begin
            m_mis[d]++;
            if (m_mis[d] >= int'(DB)) begin
               m_lvl[d] = m_s2[d];
               arr = m_lvl[d];
               m_mis[d] = 0;
            end
         end else begin
            m_mis[d] = 0;
         end
         if (lt[d] != 0 && m_q[d] > 0) begin
            m_run[d]++;
            dep = (m_run[d] % int'(SV) == 0) ? 1 : 0;
         end else begin
            m_run[d] = 0;
         end
         m_q[d] = m_q[d] + arr - dep;
         if (m_q[d] > 15) begin
            m_q[d] = 15;
            m_ovf[d] = 1;
         end
         m_s2[d] = m_s1[d];
         m_s1[d] = det[d];
      end
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [15:0] act, exp;
      act = {4'h0, EWCar, ew_queue, ew_ovf, NSCar, ns_queue, ns_ovf};
      exp = {4'h0, m_q[0] != 0, 4'(m_q[0]), m_ovf[0] != 0,
                   m_q[1] != 0, 4'(m_q[1]), m_ovf[1] != 0};
      check("model", act, exp);
   endtask

   // One clock edge, then compare DUT against the model 1ns later.
   task automatic step();
      @(posedge clock);
      if (reset) model_reset(); else model_edge();
      #1;
      check_model();
   endtask

   task automatic check_all_zero(input string name);
      check(name, {4'h0, EWCar, ew_queue, ew_ovf, NSCar, ns_queue, ns_ovf}, 16'h0);
   endtask

   // Short asynchronous reset pulse between edges.
   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      check_all_zero("async_reset");
      model_reset();
      reset = 1'b0;
   endtask

   // Lower detector long enough to settle, then raise it for one clean arrival.
   task automatic car(input bit ns);
      if (ns) ns_det = 1'b0; else ew_det = 1'b0;
      repeat (8) step();
      if (ns) ns_det = 1'b1; else ew_det = 1'b1;
      repeat (8) step();
   endtask

   typedef struct {
      logic       ew_det;
      logic       ns_det;
      logic [3:0] ew_q;
      logic       ew_car;
      logic [3:0] ns_q;
      logic       ns_car;
   } vec_t;

   vec_t tbl[7];

   initial begin
      for (int i = 0; i < 7; i++) begin
         tbl[i].ew_det = 1'b1;
         tbl[i].ns_det = (i < 3);
         tbl[i].ew_q   = (i >= 5) ? 4'd1 : 4'd0;
         tbl[i].ew_car = (i >= 5);
         tbl[i].ns_q   = 4'd0;
         tbl[i].ns_car = 1'b0;
      end

      repeat (2) @(posedge clock);
      #1;
      check_all_zero("reset_state");
      model_reset();
      reset = 1'b0;

      // Arrival latency on EW and a short NS glitch that must be rejected.
      for (int i = 0; i < 7; i++) begin
         ew_det = tbl[i].ew_det;
         ns_det = tbl[i].ns_det;
         step();
         check($sformatf("tbl%0d_ew_queue", i), 16'(ew_queue), 16'(tbl[i].ew_q));
         check($sformatf("tbl%0d_EWCar", i), 16'(EWCar), 16'(tbl[i].ew_car));
         check($sformatf("tbl%0d_ns_queue", i), 16'(ns_queue), 16'(tbl[i].ns_q));
         check($sformatf("tbl%0d_NSCar", i), 16'(NSCar), 16'(tbl[i].ns_car));
      end

      // Two waiting cars drained by continuous green.
      car(1'b0);
      check("ew_q_two", 16'(ew_queue), 16'd2);
      EWLite = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("drain_k%0d", k), 16'(ew_queue),
               (k < 8) ? 16'd2 : (k < 16) ? 16'd1 : 16'd0);
      end
      check("drain_EWCar", 16'(EWCar), 16'd0);
      EWLite = 1'b0;
      step();

      // Interrupted green discards the partial service interval.
      car(1'b0);
      EWLite = 1'b1;
      repeat (5) step();
      check("partial_q", 16'(ew_queue), 16'd1);
      EWLite = 1'b0;
      repeat (2) step();
      EWLite = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("regreen_k%0d", k), 16'(ew_queue), (k < 8) ? 16'd1 : 16'd0);
      end
      EWLite = 1'b0;

      // NS arrival landing on the departure edge leaves the queue unchanged.
      repeat (3) car(1'b1);
      check("ns_q_three", 16'(ns_queue), 16'd3);
      ns_det = 1'b0;
      repeat (8) step();
      NSLite = 1'b1;
      repeat (2) step();
      ns_det = 1'b1;
      for (int k = 3; k <= 8; k++) begin
         step();
         check($sformatf("coincide_k%0d", k), 16'(ns_queue), 16'd3);
      end
      NSLite = 1'b0;
      step();

      // Saturation and sticky overflow, then reset mid-debounce.
      pulse_reset();
      for (int n = 1; n <= 16; n++) begin
         car(1'b0);
         if (n == 15) begin
            check("sat15_q", 16'(ew_queue), 16'd15);
            check("sat15_ovf", 16'(ew_ovf), 16'd0);
         end
      end
      check("sat16_q", 16'(ew_queue), 16'd15);
      check("sat16_ovf", 16'(ew_ovf), 16'd1);
      check("sat16_ns_ovf", 16'(ns_ovf), 16'd0);
      ew_det = 1'b0;
      repeat (8) step();
      ew_det = 1'b1;
      repeat (3) step();
      pulse_reset();

      // Detector already high after reset counts as a fresh arrival.
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("post_reset_k%0d", k), 16'(ew_queue), (k < 6) ? 16'd0 : 16'd1);
      end

      // Random bouncing detectors, lights and occasional resets.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(7, 0) == 0) ew_det = ~ew_det;
         if ($urandom_range(7, 0) == 0) ns_det = ~ns_det;
         if ($urandom_range(23, 0) == 0) EWLite = ~EWLite;
         if ($urandom_range(23, 0) == 0) NSLite = ~NSLite;
         step();
         if ($urandom_range(799, 0) == 0) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/traffic_sensor.md
TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive cycles a synchronized detector level must hold before it is accepted (legal 1..15).
REQ-002 Parameter SERVICE, default 8: cycles of own-direction green per departing car (legal 1..255).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 ew_det  input  1  raw EW loop detector; asynchronous to clock; may bounce.
REQ-006 ns_det  input  1  raw NS loop detector; asynchronous to clock; may bounce.
REQ-007 EWLite  input  1  EW green from the light controller.
REQ-008 NSLite  input  1  NS green from the light controller.
REQ-009 EWCar  output  1  EW request to the controller; high when ew_queue is nonzero.
REQ-010 NSCar  output  1  NS request to the controller; high when ns_queue is nonzero.
REQ-011 ew_queue  output  4  EW waiting-car count, 0..15.
REQ-012 ns_queue  output  4  NS waiting-car count, 0..15.
REQ-013 ew_ovf  output  1  sticky; EW arrival dropped at full queue.
REQ-014 ns_ovf  output  1  sticky; NS arrival dropped at full queue.

Function
REQ-015 EW and NS paths are identical and fully independent; the requirements below apply to each.
REQ-016 Raw detector passes through a 2-flop synchronizer; no other logic reads the raw input.
REQ-017 Debouncer: holds an accepted level plus a mismatch counter.
  - Mismatch counter increments each cycle the synchronizer output differs from the accepted level.
  - Counter clears to 0 on any cycle the two agree.
  - When the count reaches DEBOUNCE, the accepted level toggles and the counter clears on that same edge.
REQ-018 Arrival = accepted level 0->1; it is counted on the edge the level toggles.
  - 1->0 toggles produce no event.
  - Timing: raw held high, first sampled at edge 1 -> queue increments at edge 2+DEBOUNCE.
REQ-019 Glitches shorter than DEBOUNCE synchronized cycles produce no arrival.
REQ-020 Service counter (8 bits):
  - Counts while own light is high and the queue is nonzero.
  - On the edge it would reach SERVICE, the queue decrements by 1 (departure) and the counter returns to 0.
  - First departure therefore comes SERVICE edges after green with a nonzero queue.
REQ-021 Service counter clears to 0 whenever own light is low or the queue is 0; a partial service interval is discarded.
REQ-022 Arrival and departure on the same edge: queue unchanged.
REQ-023 Arrival with queue = 15 and no simultaneous departure:
  - Queue stays 15.
  - ovf sets and holds until reset.
REQ-024 Departure never occurs at queue 0; the queue never wraps.
REQ-025 Both lights high together: each direction services independently; the block does no arbitration.
REQ-026 Car outputs are combinational decodes of the registered queue (queue != 0); no other combinational path from inputs to outputs.

Reset
REQ-027 Reset asserted, at any time including mid-debounce or mid-service, clears immediately:
  - synchronizers, accepted levels, mismatch counters, service counters, queues and ovf flags to 0;
  - so EWCar = NSCar = 0 and ew_queue = ns_queue = 0.
REQ-028 After reset deasserts, a detector already high is treated as a new arrival and obeys REQ-018 timing.

Verification (DEBOUNCE=4, SERVICE=8)
REQ-029 Reset, then ew_det high from edge 1 with lights low -> ew_queue 0->1 and EWCar high at edge 6; NS outputs stay 0.
REQ-030 ns_det pulses high for 3 cycles, then low -> ns_queue stays 0 and NSCar stays 0.
REQ-031 ew_queue=2, EWLite held high -> ew_queue=1 at 8th edge, 0 at 16th edge, EWCar low after 16th edge; no further change.
REQ-032 EWLite high for 5 cycles, low for 2, high again with ew_queue=1 -> no departure until 8 full cycles after the second green.
REQ-033 16 debounced EW arrivals with lights low -> ew_queue=15 and ew_ovf=1 after the 16th; a reset mid-sequence -> all outputs 0 immediately.
REQ-034 ns_queue=3, NSLite high, a new arrival lands on the departure edge -> ns_queue stays 3 on that edge.
